sw_debounce: RTL



---
 rtl/sw_debounce_pkg.sv | 22 ++
 rtl/sw_debounce_if.sv | 42 ++++
 rtl/sw_debounce_bit.sv | 95 +++++++++
 rtl/sw_debounce.sv | 66 ++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// -----------------------------------------------------------------------------
// sw_debounce_pkg
//   Shared constants and helpers for the switch debouncer.
//   - WIDTH_DEF, SYNC_STAGES_DEF, DEBOUNCE_CYCLES_DEF : default parameter values
//     used by the top level and by anything that instantiates it.
//   - cnt_width(cycles) : width of a per-bit debounce counter able to hold
//     cycles-1, never less than one bit.
// -----------------------------------------------------------------------------
package sw_debounce_pkg;

   localparam int WIDTH_DEF           = 8;
   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 1000;

   // $clog2(1) is 0, which would give a zero-width counter; clamp to 1 bit.
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_if.sv
// -----------------------------------------------------------------------------
// sw_debounce_if
//   Bundles the switch bank signals of the debouncer.
//   - sw_in      : raw asynchronous switch levels (driven by the board side)
//   - sw_out     : debounced, synchronised switch levels
//   - rise_out   : one-cycle pulse per bit on a 0->1 change of sw_out
//   - fall_out   : one-cycle pulse per bit on a 1->0 change of sw_out
//   - change_out : high in the same cycle as any rise/fall pulse
//   There is no handshake: sw_in is a free-running level and the outputs are
//   plain registered levels/pulses, valid every cycle.  A consumer treats a
//   pulse as "event present this cycle" and cannot back-pressure it.
//   Modports:
//   - master : the side that supplies sw_in and consumes the outputs
//   - slave  : the debouncer itself
// -----------------------------------------------------------------------------
interface sw_debounce_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] sw_in;
   logic [WIDTH-1:0] sw_out;
   logic [WIDTH-1:0] rise_out;
   logic [WIDTH-1:0] fall_out;
   logic             change_out;

   modport master (
      output sw_in,
      input  sw_out,
      input  rise_out,
      input  fall_out,
      input  change_out
   );

   modport slave (
      input  sw_in,
      output sw_out,
      output rise_out,
      output fall_out,
      output change_out
   );

endinterface : sw_debounce_if

// File: rtl/sw_debounce_bit.sv
// -----------------------------------------------------------------------------
// sw_debounce_bit
//   One switch bit: synchroniser chain, debounce counter, clean level register
//   and registered rise/fall pulses.
//   Ports:
//   - i_clk       : system clock, rising edge
//   - i_rst_n     : synchronous active-low reset
//   - i_sw        : raw asynchronous switch level
//   - o_level     : debounced level
//   - o_rise      : registered pulse, high the cycle o_level first shows 1
//   - o_fall      : registered pulse, high the cycle o_level first shows 0
//   - o_rise_nxt  : next-state value of o_rise (lets the parent register a
//                   summary flag aligned with o_rise/o_fall)
//   - o_fall_nxt  : next-state value of o_fall
//   - o_cnt_dbg   : current debounce count, for observation only
// -----------------------------------------------------------------------------
module sw_debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   localparam int CW             = cnt_width(DEBOUNCE_CYCLES)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_sw,
   output logic          o_level,
   output logic          o_rise,
   output logic          o_fall,
   output logic          o_rise_nxt,
   output logic          o_fall_nxt,
   output logic [CW-1:0] o_cnt_dbg
);

   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("sw_debounce_bit: SYNC_STAGES must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
      $error("sw_debounce_bit: DEBOUNCE_CYCLES must be >= 1");
   end

   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_level;
   logic                   r_rise;
   logic                   r_fall;

   logic w_sync;
   logic w_mismatch;
   logic w_accept;
   logic w_rise_nxt;
   logic w_fall_nxt;

   // Last synchroniser stage is the only point where the input is trusted.
   assign w_sync     = r_sync[SYNC_STAGES-1];
   assign w_mismatch = (w_sync != r_level);
   // Acceptance happens on the edge where the count has already reached its
   // terminal value and the mismatch is still present.
   assign w_accept   = w_mismatch && (r_cnt == CNT_MAX);
   assign w_rise_nxt = w_accept &&  w_sync;
   assign w_fall_nxt = w_accept && !w_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
         r_rise <= w_rise_nxt;
         r_fall <= w_fall_nxt;
         if (!w_mismatch) begin
            // Any return to the current level restarts the whole window.
            r_cnt <= '0;
         end else if (w_accept) begin
            r_level <= w_sync;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level    = r_level;
   assign o_rise     = r_rise;
   assign o_fall     = r_fall;
   assign o_rise_nxt = w_rise_nxt;
   assign o_fall_nxt = w_fall_nxt;
   assign o_cnt_dbg  = r_cnt;

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   Switch-bank conditioner: synchronises each raw switch bit into clk_in,
//   filters contact bounce per bit and reports clean levels plus one-cycle
//   rise/fall pulses.  Bits are fully independent.
//   Ports:
//   - clk_in     : system clock, rising edge
//   - rst_low_in : synchronous active-low reset
//   - sw_bus     : slave side of sw_debounce_if (sw_in, sw_out, rise_out,
//                  fall_out, change_out)
//   - cnt_dbg    : all per-bit debounce counts, bit i at [i*CW +: CW]
// -----------------------------------------------------------------------------
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int WIDTH           = WIDTH_DEF,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   localparam int CW             = cnt_width(DEBOUNCE_CYCLES)
) (
   input  logic                clk_in,
   input  logic                rst_low_in,
   sw_debounce_if.slave        sw_bus,
   output logic [WIDTH*CW-1:0] cnt_dbg
);

   logic [WIDTH-1:0] w_level;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_rise_nxt;
   logic [WIDTH-1:0] w_fall_nxt;
   logic             r_change;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      sw_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .i_clk      (clk_in),
         .i_rst_n    (rst_low_in),
         .i_sw       (sw_bus.sw_in[g]),
         .o_level    (w_level[g]),
         .o_rise     (w_rise[g]),
         .o_fall     (w_fall[g]),
         .o_rise_nxt (w_rise_nxt[g]),
         .o_fall_nxt (w_fall_nxt[g]),
         .o_cnt_dbg  (cnt_dbg[g*CW +: CW])
      );
   end

   // Registered from the next-state pulses so it lands in the same cycle as
   // rise_out/fall_out rather than one cycle after them.
   always_ff @(posedge clk_in) begin
      if (!rst_low_in) begin
         r_change <= 1'b0;
      end else begin
         r_change <= |(w_rise_nxt | w_fall_nxt);
      end
   end

   assign sw_bus.sw_out     = w_level;
   assign sw_bus.rise_out   = w_rise;
   assign sw_bus.fall_out   = w_fall;
   assign sw_bus.change_out = r_change;

endmodule : sw_debounce
